// File: rtl/suma_serial.sv
// suma_serial: bit-serial LSB-first adder with start/busy/done handshake
module suma_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             s_bit,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  assign s_bit = (state == RUN) & (a_r[0] ^ b_r[0] ^ carry);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        carry <= (a_r[0] & b_r[0]) | (carry & (a_r[0] ^ b_r[0]));
        a_r   <= a_r >> 1;
        b_r   <= b_r >> 1;
        res   <= {s_bit, res[WIDTH-1:1]};
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state <= DONE;
          busy  <= 1'b0;
        end
      end else begin
        if (state == DONE) begin
          S    <= res;
          Cout <= carry;
          done <= 1'b1;
        end
        if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          a_r   <= A;
          b_r   <= B;
          carry <= 1'b0;
          cnt   <= '0;
        end else begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_suma_serial.sv
// tb_suma_serial: directed self-checking bench for suma_serial
module tb_suma_serial;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0, s;
  logic       cout, s_bit, busy, done;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       cout8, s_bit8, busy8, done8;
  int         checks = 0, passed = 0;
  bit         chk_en = 1'b0;
  int         ph = 0;
  logic [4:0] msum = '0;
  logic [3:0] es = '0;
  logic       ec = 1'b0, ed = 1'b0;
  always #5 clk = ~clk;
  suma_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .S(s), .Cout(cout), .s_bit(s_bit), .busy(busy), .done(done)
  );
  suma_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .S(s8), .Cout(cout8), .s_bit(s_bit8), .busy(busy8), .done(done8)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      es = '0;
      ec = 1'b0;
      ed = 1'b0;
    end else begin
      ed = 1'b0;
      if (ph >= 1 && ph <= 4) ph++;
      else begin
        if (ph == 5) begin
          es = msum[3:0];
          ec = msum[4];
          ed = 1'b1;
        end
        if (start) begin
          msum = {1'b0, a} + {1'b0, b};
          ph = 1;
        end else ph = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (ph >= 1 && ph <= 4));
      chk("s_bit", s_bit, (ph >= 1 && ph <= 4) ? msum[ph-1] : 1'b0);
      chk("done", done, ed);
      chk("S", s, es);
      chk("Cout", cout, ec);
    end
  end
  task automatic run1(input logic [3:0] x, input logic [3:0] y, output int lat,
                      output int nb, output logic [3:0] seq);
    lat = -1;
    nb = 0;
    seq = '0;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 12 && lat < 0; n++) begin
      if (busy) begin
        if (nb < 4) seq[nb] = s_bit;
        nb++;
      end
      if (done) lat = n;
      if (lat < 0) @(negedge clk);
    end
  endtask
  initial begin
    int lat, nb, gap, nd;
    logic [3:0] seq, s1;
    logic c1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_S", s, 0);
    chk("rst_Cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    run1(4'd3, 4'd5, lat, nb, seq);
    chk("t1_latency", lat, 5);
    chk("t1_busy_cycles", nb, 4);
    chk("t1_sbit_seq", seq, 4'b1000);
    chk("t1_S", s, 8);
    chk("t1_Cout", cout, 0);
    run1(4'd15, 4'd1, lat, nb, seq);
    chk("t2_S", s, 0);
    chk("t2_Cout", cout, 1);
    run1(4'd0, 4'd0, lat, nb, seq);
    chk("t2b_S", s, 0);
    chk("t2b_Cout", cout, 0);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        run1(4'(x), 4'(y), lat, nb, seq);
        chk("t3_latency", lat, 5);
        chk("t3_sum", {cout, s}, x + y);
      end
    @(negedge clk);
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    nd = 0;
    gap = 0;
    s1 = '0;
    c1 = 1'b0;
    for (int n = 0; n < 20 && nd < 2; n++) begin
      if (nd == 1) gap++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          s1 = s;
          c1 = cout;
          start = 1'b0;
          a = 4'd1;
          b = 4'd1;
        end
      end
      if (nd < 2) @(negedge clk);
    end
    chk("t4_dones", nd, 2);
    chk("t4_first", {c1, s1}, 13);
    chk("t4_second", {cout, s}, 18);
    chk("t4_gap", gap, 5);
    @(negedge clk);
    a = 4'd10;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_S", s, 0);
    chk("t5_Cout", cout, 0);
    run1(4'd7, 4'd8, lat, nb, seq);
    chk("t5_fresh", {cout, s}, 15);
    @(negedge clk);
    a8 = 8'd200;
    b8 = 8'd100;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int n = 0; n <= 20 && lat < 0; n++) begin
      if (done8) lat = n;
      if (lat < 0) @(negedge clk);
    end
    chk("t6_latency", lat, 9);
    chk("t6_S", s8, 44);
    chk("t6_Cout", cout8, 1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
